// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// fetch_sequencer: PC owner and instruction fetch/issue FSM feeding the decoder
// Rev 1.0
// ============================================================================
module fetch_sequencer #(
  parameter int                INSTR_W  = 18,
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  output logic [ADDR_W-1:0]  o_imemAddr,
  output logic               o_imemReq,
  input  logic [INSTR_W-1:0] i_imemData,
  input  logic               i_imemValid,
  output logic [INSTR_W-1:0] o_instruction,
  output logic               o_instrValid,
  input  logic               i_stall,
  input  logic               i_jumpTaken,
  input  logic [ADDR_W-1:0]  i_jumpTarget,
  input  logic               i_halt,
  output logic [ADDR_W-1:0]  o_pc,
  output logic               o_halted,
  output logic [15:0]        o_retireCount
);

  localparam logic [1:0] S_FETCH  = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ISSUE  = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  logic [1:0]         state_q,  state_d;
  logic [ADDR_W-1:0]  pc_q,     pc_d;
  logic [INSTR_W-1:0] instr_q,  instr_d;
  logic               valid_q,  valid_d;
  logic               halted_q, halted_d;
  logic [15:0]        retire_q, retire_d;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    retire_d = retire_q;
    case (state_q)
      S_FETCH: begin
        state_d = i_halt ? S_HALTED : S_WAIT;
      end
      S_WAIT: begin
        // halt is deliberately not sampled here so the outstanding read retires
        if (i_imemValid) begin
          instr_d = i_imemData;
          valid_d = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!i_stall) begin
          pc_d     = i_jumpTaken ? i_jumpTarget : pc_q + ADDR_W'(1);
          valid_d  = 1'b0;
          retire_d = retire_q + 16'd1;
          state_d  = i_halt ? S_HALTED : S_FETCH;
        end
      end
      S_HALTED: begin
        if (!i_halt) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    halted_d = (state_d == S_HALTED);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      retire_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      retire_q <= retire_d;
    end
  end

  assign o_imemReq     = (state_q == S_FETCH) && !i_halt;
  assign o_imemAddr    = pc_q;
  assign o_pc          = pc_q;
  assign o_instruction = instr_q;
  assign o_instrValid  = valid_q;
  assign o_halted      = halted_q;
  assign o_retireCount = retire_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// tb_fetch_sequencer: directed scoreboard bench for fetch_sequencer
// Rev 1.0
// ============================================================================
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] i_imemData;
  logic        i_imemValid;
  logic        i_stall;
  logic        i_jumpTaken;
  logic [15:0] i_jumpTarget;
  logic        i_halt;

  logic [15:0] a_addr, a_pc, a_retire;
  logic        a_req, a_valid, a_halted;
  logic [17:0] a_instr;
  logic [15:0] b_addr, b_pc, b_retire;
  logic        b_req, b_valid, b_halted;
  logic [17:0] b_instr;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [17:0] sb_q[$];

  fetch_sequencer #(.INSTR_W(18), .ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .i_clk(clk), .i_rst(rst),
    .o_imemAddr(a_addr), .o_imemReq(a_req),
    .i_imemData(i_imemData), .i_imemValid(i_imemValid),
    .o_instruction(a_instr), .o_instrValid(a_valid),
    .i_stall(i_stall), .i_jumpTaken(i_jumpTaken), .i_jumpTarget(i_jumpTarget),
    .i_halt(i_halt), .o_pc(a_pc), .o_halted(a_halted), .o_retireCount(a_retire)
  );

  fetch_sequencer #(.INSTR_W(18), .ADDR_W(16), .RESET_PC(16'hFFFF)) dut_wrap (
    .i_clk(clk), .i_rst(rst),
    .o_imemAddr(b_addr), .o_imemReq(b_req),
    .i_imemData(i_imemData), .i_imemValid(i_imemValid),
    .o_instruction(b_instr), .o_instrValid(b_valid),
    .i_stall(i_stall), .i_jumpTaken(i_jumpTaken), .i_jumpTarget(i_jumpTarget),
    .i_halt(i_halt), .o_pc(b_pc), .o_halted(b_halted), .o_retireCount(b_retire)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(output int at);
    int k = 0;
    while (!a_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("req_seen", {31'b0, a_req}, 32'd1);
    at = cyc;
  endtask

  // One full instruction: request, memory reply after lat cycles, optional stall, consume.
  task automatic run_instr(input logic [15:0] addr, input logic [17:0] data, input int lat,
                           input int stall, input logic jt, input logic [15:0] tgt,
                           input logic halt_in_wait, output int req_at);
    logic [15:0] pc0, rc0;
    logic [17:0] exp;
    wait_req(req_at);
    chk("fetch_addr", a_addr, addr);
    chk("pc_eq_addr", a_pc, addr);
    @(negedge clk);
    if (halt_in_wait) i_halt = 1'b1;
    for (int i = 1; i < lat; i++) begin
      chk("no_req_in_wait", a_req, 0);
      chk("no_valid_in_wait", a_valid, 0);
      @(negedge clk);
    end
    i_imemValid = 1'b1;
    i_imemData  = data;
    sb_q.push_back(data);
    @(negedge clk);
    i_imemValid = 1'b0;
    i_imemData  = 18'($urandom);
    chk("instr_valid", a_valid, 1);
    exp = sb_q.pop_front();
    chk("instr_word", a_instr, exp);
    pc0 = a_pc;
    rc0 = a_retire;
    for (int i = 0; i < stall; i++) begin
      i_stall      = 1'b1;
      i_jumpTaken  = 1'($urandom_range(0, 1));
      i_jumpTarget = 16'($urandom);
      i_imemValid  = 1'b1;
      i_imemData   = ~data;
      @(negedge clk);
      chk("stall_instr_hold", a_instr, exp);
      chk("stall_valid_hold", a_valid, 1);
      chk("stall_no_req", a_req, 0);
      chk("stall_pc_hold", a_pc, pc0);
      chk("stall_retire_hold", a_retire, rc0);
    end
    i_imemValid  = 1'b0;
    i_stall      = 1'b0;
    i_jumpTaken  = jt;
    i_jumpTarget = tgt;
    @(negedge clk);
    i_jumpTaken  = 1'b0;
    i_jumpTarget = 16'($urandom);
    chk("consume_valid_low", a_valid, 0);
    chk("consume_instr_kept", a_instr, exp);
    chk("consume_retire", a_retire, rc0 + 16'd1);
    chk("consume_next_pc", a_pc, jt ? tgt : pc0 + 16'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, tx;
    rst = 1'b1; i_imemData = '0; i_imemValid = 1'b0; i_stall = 1'b0;
    i_jumpTaken = 1'b0; i_jumpTarget = '0; i_halt = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pc", a_pc, 16'h0000);
    chk("rst_instr", a_instr, 0);
    chk("rst_valid", a_valid, 0);
    chk("rst_halted", a_halted, 0);
    chk("rst_retire", a_retire, 0);
    chk("rst_pc_wrapdut", b_pc, 16'hFFFF);
    rst = 1'b0;

    // Back-to-back fetch with 1-cycle memory, no stall.
    run_instr(16'h0000, 18'h3F00F, 1, 0, 1'b0, 16'h0, 1'b0, t0);
    chk("wrap_second_addr", b_addr, 16'h0000);
    run_instr(16'h0001, 18'h00001, 1, 0, 1'b0, 16'h0, 1'b0, t1);
    chk("throughput_3cyc", t1 - t0, 3);
    chk("pc_after_two", a_pc, 16'h0002);
    chk("retire_after_two", a_retire, 16'd2);

    // Stall with jump lines toggling, then taken jump on consume.
    run_instr(16'h0002, 18'h2B3C4, 1, 5, 1'b1, 16'h1234, 1'b0, tx);
    run_instr(16'h1234, 18'h11111, 2, 0, 1'b0, 16'h0, 1'b0, tx);

    // Halt raised while a 4-cycle read is outstanding.
    run_instr(16'h1235, 18'h0F0F0, 4, 0, 1'b0, 16'h0, 1'b1, tx);
    for (int i = 0; i < 4; i++) begin
      chk("halted_flag", a_halted, 1);
      chk("halted_no_req", a_req, 0);
      chk("halted_pc", a_pc, 16'h1236);
      @(negedge clk);
    end
    i_halt = 1'b0;
    @(negedge clk);
    chk("unhalt_flag", a_halted, 0);
    run_instr(16'h1236, 18'h3FFFF, 1, 0, 1'b0, 16'h0, 1'b0, tx);

    // Reset in the middle of WAIT; a late reply right after reset must be ignored.
    wait_req(tx);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", a_valid, 0);
    chk("midrst_pc", a_pc, 16'h0000);
    chk("midrst_retire", a_retire, 0);
    @(negedge clk);
    rst = 1'b0;
    chk("postrst_req", a_req, 1);
    chk("postrst_addr", a_addr, 16'h0000);
    i_imemValid = 1'b1;
    i_imemData  = 18'h2AAAA;
    @(negedge clk);
    i_imemValid = 1'b0;
    chk("late_reply_ignored_valid", a_valid, 0);
    chk("late_reply_ignored_instr", a_instr, 0);
    chk("late_reply_no_req", a_req, 0);
    i_imemValid = 1'b1;
    i_imemData  = 18'h15555;
    sb_q.push_back(18'h15555);
    @(negedge clk);
    i_imemValid = 1'b0;
    chk("fresh_valid", a_valid, 1);
    chk("fresh_instr", a_instr, sb_q.pop_front());
    @(negedge clk);
    chk("fresh_retire", a_retire, 16'd1);
    chk("fresh_next_pc", a_pc, 16'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
